memoria_dados_param: RTL and testbench
======================================

Name: memoria_dados_param

Overview:
- Parametrised successor to the single-cycle data memory of the RISC-V datapath.
- Word-addressed data store with:
  - valid/ready request port
  - byte-enable writes
  - configurable read latency
  - range checking
  - a hardware clear sweep that replaces the one-cycle init loop
- Sits between the ALU result (address) and the write-back mux.
- Exposes a flattened full-memory view for the bench.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; need not be a power of two.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.
- READ_LAT, 1, cycles from accepted request to response; legal values 1..4.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  start a clear sweep (level sampled in RUN).
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  accepted address was >= DEPTH; qualified by rsp_valid.
- busy  out  1  high while clear sweep in progress.
- dump_out  out  DATA_W*DEPTH  word j at [DATA_W*j +: DATA_W]; registered copy of the array, updated every cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clr_cnt=0.
  - Response pipeline valids cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, dump_out=0.
  - busy=1, req_ready=0.
  - Array contents are not reset directly; the sweep zeroes them.
- CLEAR state:
  - Writes 0 to word clr_cnt each cycle, then increments.
  - At clr_cnt==DEPTH-1, goes to RUN on the same edge as the final write.
  - Sweep takes exactly DEPTH cycles.
  - busy=1, req_ready=0; clear_req ignored.
- RUN state:
  - busy=0.
  - req_ready = !clear_req (combinational).
  - clear_req=1 moves to CLEAR next edge with clr_cnt=0; a simultaneous req_valid is not accepted.
- Accepted write:
  - Bytes with req_be[k]=1 updated at the accepting edge; other bytes unchanged.
  - req_be=0 is a legal no-op that still responds.
- Accepted read: array sampled at the accepting edge, before any write in that same edge (none possible, one request per cycle).
- Ordering: a read accepted the cycle after a write to the same address returns the new data.
- Response timing:
  - rsp_valid asserted exactly READ_LAT cycles after acceptance, for both reads and writes.
  - Responses are in order, one per accepted request.
  - No response backpressure.
  - Back-to-back acceptance every cycle is allowed.
- Out of range (req_addr >= DEPTH):
  - Write suppressed.
  - Read data forced to 0.
  - rsp_err=1 with the response.
- Clear during traffic: responses already in the pipeline still emerge on schedule with data sampled at acceptance.
- Reset mid-operation: pipeline flushed; no response for in-flight requests; sweep restarts at 0 after reset returns high.
- dump_out: copy of the array registered each cycle; lags array writes by one cycle.

Decomposition:
- Package mem_pkg:
  - state enum {CLEAR, RUN}
  - localparam BE_W = DATA_W/8
  - function for byte-masked merge
- One sub-module, pipe_atraso:
  - parametrised delay line carrying {valid, err, data}, with stage count READ_LAT
  - async active-low reset clears valid bits

Test Plan:
- Reset release, DEPTH=32: busy=1 for exactly 32 cycles; req_ready=0 throughout; then dump_out all zero, busy=0, req_ready=1.
- Write addr 5 data 0xDEADBEEF be=4'b1111, then write addr 5 data 0x00001234 be=4'b0011, then read addr 5 → rsp_rdata=0xDEAD1234, rsp_err=0, one cycle after each acceptance (READ_LAT=1).
- READ_LAT=3: back-to-back reads of addr 0,1,2 preloaded with 1,2,3 → rsp_valid high 3 consecutive cycles starting 3 cycles after first accept, data 1,2,3 in order.
- DEPTH=20, ADDR_W=5: write addr 25 data 0xFF → rsp_err=1; dump_out unchanged; read addr 25 → rsp_rdata=0, rsp_err=1.
- clear_req asserted with req_valid in the same cycle, after writing addr 3=0x77 → req_ready=0 that cycle; busy for DEPTH cycles; a read issued the cycle before clear_req still returns 0x77; afterwards read addr 3 → 0.
- Reset pulsed while a READ_LAT=2 read is in flight → no rsp_valid for it; new sweep of DEPTH cycles starts after reset deasserts.

Source files
------------

// File: rtl/memoria_dados_param_pkg.sv
// Shared types and helpers for the parametrised data memory.
// Holds the controller state encoding and the byte-lane write merge.
package mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned BE_W        = DATA_W_DFLT / 8;

  // One byte lane of a masked write: take the new byte only when its enable is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    logic [7:0] res;
    if (en) begin
      res = new_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

endpackage

// File: rtl/memoria_dados_param_pipe_atraso.sv
// Response delay line: carries {valid, err, data} through STAGES registers.
// Reset empties the line so in-flight responses are dropped.
module pipe_atraso #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_err,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_err,
  output logic [W-1:0] out_data
);

  localparam int NS = int'(STAGES);

  logic [W+1:0] stage_q [NS];
  logic [W+1:0] stage_d [NS];

  // Shift: stage 0 takes the new entry, each later stage takes its predecessor.
  always_comb begin
    stage_d[0] = {in_valid, in_err, in_data};
    for (int s = 1; s < NS; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  // Delay registers, emptied by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign {out_valid, out_err, out_data} = stage_q[NS-1];

endmodule

// File: rtl/memoria_dados_param.sv
// Word-addressed data memory with byte-enable writes, fixed read latency,
// range checking and a hardware zeroing sweep after reset or on request.
module memoria_dados_param
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_req,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_be,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [DATA_W*DEPTH-1:0] dump_out
);

  localparam int                NBE      = int'(DATA_W / 8);
  localparam int                DEPTH_I  = int'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]       mem_q [DEPTH_I];
  logic [DATA_W-1:0]       mem_d [DEPTH_I];
  logic [DATA_W*DEPTH-1:0] dump_q, dump_d;

  logic              busy_s, ready_s, accept_s, in_range_s;
  logic              pipe_err_s;
  logic [DATA_W-1:0] rd_word_s, wr_word_s, pipe_data_s;

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: the sweep leaves CLEAR on the same edge as its last write.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Controller outputs; a pending clear_req blocks acceptance in the same cycle.
  always_comb begin
    case (state_q)
      RUN: begin
        busy_s  = 1'b0;
        ready_s = !clear_req;
      end
      default: begin
        busy_s  = 1'b1;
        ready_s = 1'b0;
      end
    endcase
  end

  // Request decode, array read before the edge, and the byte-merged write word.
  always_comb begin
    accept_s   = req_valid && ready_s;
    in_range_s = ({1'b0, req_addr} < DEPTH_L);
    if (in_range_s) begin
      rd_word_s = mem_q[req_addr];
    end else begin
      rd_word_s = '0;
    end
    for (int k = 0; k < NBE; k++) begin
      wr_word_s[8*k +: 8] = byte_merge(rd_word_s[8*k +: 8], req_wdata[8*k +: 8], req_be[k]);
    end
    if (accept_s && !req_we) begin
      pipe_data_s = rd_word_s;
    end else begin
      pipe_data_s = '0;
    end
    pipe_err_s = accept_s && !in_range_s;
  end

  // Array next value: sweep writes take priority; out-of-range writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_cnt_q] = '0;
    end else if (accept_s && req_we && in_range_s) begin
      mem_d[req_addr] = wr_word_s;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array; contents are zeroed by the sweep rather than by reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Flattened view of the array for observation.
  always_comb begin
    dump_d = '0;
    for (int j = 0; j < DEPTH_I; j++) begin
      dump_d[DATA_W*j +: DATA_W] = mem_q[j];
    end
  end

  // Registered copy of the array, one cycle behind it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dump_q <= '0;
    end else begin
      dump_q <= dump_d;
    end
  end

  pipe_atraso #(
    .W      (DATA_W),
    .STAGES (READ_LAT)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (accept_s),
    .in_err    (pipe_err_s),
    .in_data   (pipe_data_s),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_rdata)
  );

  assign busy      = busy_s;
  assign req_ready = ready_s;
  assign dump_out  = dump_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// Bench for memoria_dados_param: three configurations share one stimulus
// stream and are checked every cycle against a behavioural memory model.
module tb_memoria_dados_param;

  localparam int NI = 3;
  localparam int DEP [NI] = '{32, 32, 20};
  localparam int LAT [NI] = '{1, 3, 2};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;

  logic        rdy [NI];
  logic        rv  [NI];
  logic        re  [NI];
  logic        bsy [NI];
  logic [31:0] rd  [NI];
  logic [1023:0] dump_a, dump_b;
  logic [639:0]  dump_c;

  always #5 clock = ~clock;

  memoria_dados_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .READ_LAT(1)) u_a (
    .clock(clock), .reset(reset), .clear_req(clear_req), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]),
    .busy(bsy[0]), .dump_out(dump_a));

  memoria_dados_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .READ_LAT(3)) u_b (
    .clock(clock), .reset(reset), .clear_req(clear_req), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]),
    .busy(bsy[1]), .dump_out(dump_b));

  memoria_dados_param #(.DATA_W(32), .DEPTH(20), .ADDR_W(5), .READ_LAT(2)) u_c (
    .clock(clock), .reset(reset), .clear_req(clear_req), .req_valid(req_valid),
    .req_ready(rdy[2]), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]),
    .busy(bsy[2]), .dump_out(dump_c));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dump_word(input int i, input int w);
    case (i)
      0:       return dump_a[32*w +: 32];
      1:       return dump_b[32*w +: 32];
      default: return dump_c[32*w +: 32];
    endcase
  endfunction

  // Model: memory contents, which words hold defined values, one-cycle-late
  // copy of the array, and responses scheduled by the cycle they are due.
  logic [31:0] mem_m   [NI][32];
  bit          known_m [NI][32];
  logic [31:0] dump_m  [NI][32];
  bit          dumpk_m [NI][32];
  bit          run_m   [NI];
  int          clr_m   [NI];
  bit          sv [NI][8];
  bit          se [NI][8];
  logic [31:0] sd [NI][8];
  int          cyc = 0;

  task automatic model_step();
    bit ok;
    int d;
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        run_m[i] = 1'b0;
        clr_m[i] = 0;
        for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
        for (int w = 0; w < 32; w++) begin
          dump_m[i][w]  = 32'd0;
          dumpk_m[i][w] = 1'b1;
        end
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        sv[i][(cyc-1)%8] = 1'b0;
        for (int w = 0; w < 32; w++) begin
          dump_m[i][w]  = mem_m[i][w];
          dumpk_m[i][w] = known_m[i][w];
        end
        if (!run_m[i]) begin
          mem_m[i][clr_m[i]]   = 32'd0;
          known_m[i][clr_m[i]] = 1'b1;
          if (clr_m[i] == DEP[i] - 1) run_m[i] = 1'b1;
          else clr_m[i]++;
        end else if (clear_req) begin
          run_m[i] = 1'b0;
          clr_m[i] = 0;
        end else if (req_valid) begin
          ok = (int'(req_addr) < DEP[i]);
          d  = (cyc + LAT[i] - 1) % 8;
          sv[i][d] = 1'b1;
          se[i][d] = !ok;
          sd[i][d] = 32'd0;
          if (ok && req_we) begin
            for (int k = 0; k < 4; k++)
              if (req_be[k]) mem_m[i][req_addr][8*k +: 8] = req_wdata[8*k +: 8];
          end else if (ok) begin
            sd[i][d] = mem_m[i][req_addr];
          end
        end
      end
    end
  endtask

  task automatic compare_step();
    bit ev;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("busy[%0d]", i), 64'(bsy[i]), 64'(!run_m[i]));
      chk($sformatf("req_ready[%0d]", i), 64'(rdy[i]), 64'(run_m[i] && !clear_req));
      ev = reset && sv[i][cyc%8];
      chk($sformatf("rsp_valid[%0d] cyc %0d", i, cyc), 64'(rv[i]), 64'(ev));
      if (ev) begin
        chk($sformatf("rsp_rdata[%0d] cyc %0d", i, cyc), 64'(rd[i]), 64'(sd[i][cyc%8]));
        chk($sformatf("rsp_err[%0d] cyc %0d", i, cyc), 64'(re[i]), 64'(se[i][cyc%8]));
      end
      if (!reset) begin
        chk($sformatf("reset rsp_rdata[%0d]", i), 64'(rd[i]), 64'd0);
        chk($sformatf("reset rsp_err[%0d]", i), 64'(re[i]), 64'd0);
      end
      for (int w = 0; w < DEP[i]; w++)
        if (dumpk_m[i][w])
          chk($sformatf("dump[%0d] word %0d", i, w), 64'(dump_word(i, w)), 64'(dump_m[i][w]));
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    compare_step();
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] dat, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = dat;
    req_be    = be;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (n) step();
  endtask

  task automatic count_busy(output int ca, output int cc);
    ca = 0;
    cc = 0;
    repeat (45) begin
      @(negedge clock);
      if (bsy[0]) ca++;
      if (bsy[2]) cc++;
    end
    step();
  endtask

  int ca, cc;
  logic [639:0] dump_c_saved;

  initial begin
    repeat (3) step();
    chk("reset busy", 64'(bsy[0]), 64'd1);
    chk("reset req_ready", 64'(rdy[0]), 64'd0);
    chk("reset rsp_valid", 64'(rv[0]), 64'd0);
    chk("reset dump zero", 64'((dump_a == '0) && (dump_c == '0)), 64'd1);

    // Sweep after reset release: DEPTH cycles of busy.
    reset = 1'b1;
    count_busy(ca, cc);
    chk("sweep cycles depth32", 64'(ca), 64'd32);
    chk("sweep cycles depth20", 64'(cc), 64'd20);
    chk("dump zero after sweep", 64'((dump_a == '0) && (dump_b == '0) && (dump_c == '0)), 64'd1);
    chk("ready after sweep", 64'(rdy[0]), 64'd1);

    // Byte-enable merge.
    issue(1'b1, 5'd5, 32'hDEADBEEF, 4'b1111);
    chk("wr1 rsp_valid", 64'(rv[0]), 64'd1);
    chk("wr1 rsp_rdata", 64'(rd[0]), 64'd0);
    issue(1'b1, 5'd5, 32'h00001234, 4'b0011);
    chk("wr2 rsp_valid", 64'(rv[0]), 64'd1);
    issue(1'b0, 5'd5, 32'd0, 4'b0000);
    chk("rd5 rsp_valid", 64'(rv[0]), 64'd1);
    chk("rd5 rsp_rdata", 64'(rd[0]), 64'hDEAD1234);
    chk("rd5 rsp_err", 64'(re[0]), 64'd0);
    idle(2);

    // Back-to-back reads through the three-stage line.
    issue(1'b1, 5'd0, 32'd1, 4'hF);
    issue(1'b1, 5'd1, 32'd2, 4'hF);
    issue(1'b1, 5'd2, 32'd3, 4'hF);
    idle(3);
    issue(1'b0, 5'd0, 32'd0, 4'h0);
    chk("lat3 early 0", 64'(rv[1]), 64'd0);
    issue(1'b0, 5'd1, 32'd0, 4'h0);
    chk("lat3 early 1", 64'(rv[1]), 64'd0);
    issue(1'b0, 5'd2, 32'd0, 4'h0);
    chk("lat3 data 1 valid", 64'(rv[1]), 64'd1);
    chk("lat3 data 1", 64'(rd[1]), 64'd1);
    idle(1);
    chk("lat3 data 2", 64'(rd[1]), 64'd2);
    idle(1);
    chk("lat3 data 3 valid", 64'(rv[1]), 64'd1);
    chk("lat3 data 3", 64'(rd[1]), 64'd3);
    idle(1);
    chk("lat3 done", 64'(rv[1]), 64'd0);
    idle(2);

    // Address 25: out of range for DEPTH=20, in range for DEPTH=32.
    dump_c_saved = dump_c;
    issue(1'b1, 5'd25, 32'h000000FF, 4'hF);
    chk("oor wr not yet", 64'(rv[2]), 64'd0);
    issue(1'b0, 5'd25, 32'd0, 4'h0);
    chk("oor wr rsp_valid", 64'(rv[2]), 64'd1);
    chk("oor wr rsp_err", 64'(re[2]), 64'd1);
    chk("inrange rd25", 64'(rd[0]), 64'hFF);
    idle(1);
    chk("oor rd rsp_err", 64'(re[2]), 64'd1);
    chk("oor rd rsp_rdata", 64'(rd[2]), 64'd0);
    idle(2);
    chk("oor dump unchanged", 64'(dump_c == dump_c_saved), 64'd1);

    // Clear sweep requested while a request is offered.
    issue(1'b1, 5'd3, 32'h77, 4'hF);
    issue(1'b0, 5'd3, 32'd0, 4'h0);
    clear_req = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("clear ready a", 64'(rdy[0]), 64'd0);
    chk("clear ready c", 64'(rdy[2]), 64'd0);
    chk("pre-clear read", 64'(rd[0]), 64'h77);
    step();
    clear_req = 1'b0;
    req_valid = 1'b0;
    count_busy(ca, cc);
    chk("clear cycles depth32", 64'(ca), 64'd32);
    chk("clear cycles depth20", 64'(cc), 64'd20);
    issue(1'b0, 5'd3, 32'd0, 4'h0);
    chk("post-clear read", 64'(rd[0]), 64'd0);
    chk("post-clear valid", 64'(rv[0]), 64'd1);
    idle(4);

    // Reset while a read is in flight.
    issue(1'b0, 5'd1, 32'd0, 4'h0);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("inflight dropped now", 64'(rv[2]), 64'd0);
    step();
    chk("inflight dropped later", 64'(rv[2]), 64'd0);
    step();
    reset = 1'b1;
    count_busy(ca, cc);
    chk("resweep depth32", 64'(ca), 64'd32);
    chk("resweep depth20", 64'(cc), 64'd20);
    issue(1'b0, 5'd5, 32'd0, 4'h0);
    chk("resweep read5", 64'(rd[0]), 64'd0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
